// File: rtl/image_line_feeder_pkg.sv
// Shared constants and FSM state type for the image line feeder.
//   LINE_WIDTH/IMG_LINES/PAD_LINES/PRELOAD_LINES : default frame geometry
//   ADDR_W  : default memory address width
//   PIXEL_W : greyscale pixel width
package img_pkg;

  localparam int LINE_WIDTH    = 512;
  localparam int IMG_LINES     = 512;
  localparam int PAD_LINES     = 2;
  localparam int PRELOAD_LINES = 4;
  localparam int ADDR_W        = 18;
  localparam int PIXEL_W       = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_CREDIT,
    FLUSH
  } state_e;

endpackage

// File: rtl/image_line_feeder_if.sv
// Memory read bus and pixel stream of the image line feeder.
//   master : feeder side (drives MEM_EN/MEM_ADDR/PIXEL_DATA/PIXEL_DATA_VALID)
//   slave  : memory + controller side (drives MEM_RDATA and INT)
interface image_line_feeder_if #(
  parameter int ADDR_W = img_pkg::ADDR_W
);
  import img_pkg::*;

  logic               MEM_EN;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [PIXEL_W-1:0] MEM_RDATA;
  logic               INT;
  logic [PIXEL_W-1:0] PIXEL_DATA;
  logic               PIXEL_DATA_VALID;

  modport master (
    output MEM_EN, MEM_ADDR, PIXEL_DATA, PIXEL_DATA_VALID,
    input  MEM_RDATA, INT
  );

  modport slave (
    input  MEM_EN, MEM_ADDR, PIXEL_DATA, PIXEL_DATA_VALID,
    output MEM_RDATA, INT
  );

endinterface

// File: rtl/image_line_feeder_credit.sv
// Line credit counter for the image line feeder.
//   CLK, RESETH : clock, synchronous active-high reset
//   load        : accepted START, credits set to PRELOAD_LINES
//   idle        : feeder is idle; INT is then ignored and flagged
//   int_pulse   : controller consumed a line, +1 credit
//   line_end    : last pixel of a line issued, -1 credit
//   credits     : current credit count (ceiling PRELOAD_LINES)
//   err         : sticky; INT at the ceiling or while idle
module line_credit_counter #(
  parameter int PRELOAD_LINES = img_pkg::PRELOAD_LINES,
  parameter int CRED_W        = $clog2(PRELOAD_LINES + 1)
) (
  input  logic              CLK,
  input  logic              RESETH,
  input  logic              load,
  input  logic              idle,
  input  logic              int_pulse,
  input  logic              line_end,
  output logic [CRED_W-1:0] credits,
  output logic              err
);
  import img_pkg::*;

  localparam logic [CRED_W-1:0] CEIL = CRED_W'(PRELOAD_LINES);

  always_ff @(posedge CLK) begin
    if (RESETH) begin
      credits <= '0;
      err     <= 1'b0;
    end else if (idle) begin
      if (int_pulse) err <= 1'b1;
      if (load) credits <= CEIL;
    end else if (int_pulse && !line_end) begin
      if (credits == CEIL) err <= 1'b1;
      else                 credits <= credits + 1'b1;
    end else if (line_end && !int_pulse && credits != '0) begin
      credits <= credits - 1'b1;
    end
    // int_pulse together with line_end nets to zero change
  end

endmodule

// File: rtl/image_line_feeder.sv
// Streams a greyscale frame from a synchronous-read memory to the line-buffer
// controller, one line per credit, followed by zero-valued pad lines.
//   CLK, RESETH : clock, synchronous active-high reset
//   START       : single-cycle frame start (ignored unless idle)
//   BASE_ADDR   : first pixel address, sampled on accepted START
//   bus         : memory read port + pixel stream + INT credit return
//   BUSY        : frame in progress (drops in the DONE cycle)
//   DONE        : single-cycle end-of-frame pulse
//   ERR         : sticky credit protocol error
module image_line_feeder #(
  parameter int LINE_WIDTH    = img_pkg::LINE_WIDTH,
  parameter int IMG_LINES     = img_pkg::IMG_LINES,
  parameter int PAD_LINES     = img_pkg::PAD_LINES,
  parameter int PRELOAD_LINES = img_pkg::PRELOAD_LINES,
  parameter int ADDR_W        = img_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESETH,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  image_line_feeder_if.master bus,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  import img_pkg::*;

  localparam int TOTAL_LINES = IMG_LINES + PAD_LINES;
  localparam int COL_W       = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int LINE_W      = $clog2(TOTAL_LINES + 1);
  localparam int CRED_W      = $clog2(PRELOAD_LINES + 1);

  state_e             state, state_nx;
  logic [COL_W-1:0]   col;
  logic [LINE_W-1:0]  line;
  logic [ADDR_W-1:0]  addr;
  logic [CRED_W-1:0]  credits;
  logic               cred_err;
  logic               start_ok, issue, pad, line_end, last_line, is_idle;
  logic               s1_valid, s1_pad;

  line_credit_counter #(
    .PRELOAD_LINES (PRELOAD_LINES),
    .CRED_W        (CRED_W)
  ) u_credit (
    .CLK       (CLK),
    .RESETH    (RESETH),
    .load      (start_ok),
    .idle      (is_idle),
    .int_pulse (bus.INT),
    .line_end  (line_end),
    .credits   (credits),
    .err       (cred_err)
  );

  always_comb begin
    is_idle   = (state == IDLE);
    start_ok  = is_idle && START;
    issue     = (state == STREAM) && (credits != '0);
    pad       = (line >= LINE_W'(IMG_LINES));
    line_end  = issue && (col == COL_W'(LINE_WIDTH - 1));
    last_line = (line == LINE_W'(TOTAL_LINES - 1));
  end

  always_comb begin
    state_nx = state;
    DONE     = 1'b0;
    case (state)
      IDLE:        if (START) state_nx = STREAM;
      STREAM: begin
        if (line_end) begin
          if (last_line) state_nx = FLUSH;
          // credits==1 without a coincident INT reaches zero at this line end
          else if (credits == CRED_W'(1) && !bus.INT) state_nx = WAIT_CREDIT;
        end
      end
      WAIT_CREDIT: if (credits != '0) state_nx = STREAM;
      FLUSH: begin
        // last issue has left stage 1; stage 2 presents it in this cycle
        if (!s1_valid) begin
          DONE     = 1'b1;
          state_nx = IDLE;
        end
      end
      default:     state_nx = IDLE;
    endcase
  end

  always_comb begin
    BUSY         = !is_idle && !DONE;
    ERR          = cred_err;
    bus.MEM_EN   = issue && !pad;
    bus.MEM_ADDR = addr;
  end

  always_ff @(posedge CLK) begin
    if (RESETH) state <= IDLE;
    else        state <= state_nx;
  end

  // Image lines are contiguous in memory, so the address simply increments.
  always_ff @(posedge CLK) begin
    if (RESETH) begin
      col  <= '0;
      line <= '0;
      addr <= '0;
    end else if (start_ok) begin
      col  <= '0;
      line <= '0;
      addr <= BASE_ADDR;
    end else if (issue) begin
      if (!pad) addr <= addr + 1'b1;
      if (line_end) begin
        col  <= '0;
        line <= line + 1'b1;
      end else begin
        col  <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESETH) begin
      s1_valid             <= 1'b0;
      s1_pad               <= 1'b0;
      bus.PIXEL_DATA       <= '0;
      bus.PIXEL_DATA_VALID <= 1'b0;
    end else begin
      s1_valid             <= issue;
      s1_pad               <= pad;
      bus.PIXEL_DATA       <= (s1_valid && !s1_pad) ? bus.MEM_RDATA : '0;
      bus.PIXEL_DATA_VALID <= s1_valid;
    end
  end

endmodule
